stdp_weight_bank: RTL

Synaptic weight store and write-back engine on the other side of the STDP weight-update interface. It holds `N_SYN` weights and drives them in parallel as the previous-weight operand to `N_SYN` STDP update units. It frames the replay window those units adapt in, captures their updated weights, and commits them back to the array one synapse per cycle. A host port loads and reads weights while the block is idle.

---
 rtl/stdp_bank_if.sv | 28 ++
 rtl/stdp_weight_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/stdp_bank_if.sv
// Host/control bundle for stdp_weight_bank: run handshake, host write/read port
// and pass statistics. The master drives requests, the slave is the weight bank.
interface stdp_bank_if #(
    parameter int buffer_size = 16,
    parameter int AW          = 3
);
    logic                   start;
    logic [7:0]             replay_len;
    logic                   busy;
    logic                   done;
    logic                   start_replay_phase;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [buffer_size-1:0] wr_data;
    logic [AW-1:0]          rd_addr;
    logic [buffer_size-1:0] rd_data;
    logic [AW:0]            n_changed;

    modport master (
        output start, replay_len, wr_en, wr_addr, wr_data, rd_addr,
        input  busy, done, start_replay_phase, rd_data, n_changed
    );

    modport slave (
        input  start, replay_len, wr_en, wr_addr, wr_data, rd_addr,
        output busy, done, start_replay_phase, rd_data, n_changed
    );
endinterface

// File: rtl/stdp_weight_bank.sv
// Synaptic weight store: frames the STDP replay window, captures updated weights
// into a shadow copy and commits them back one synapse per cycle.
// Optional macro STDP_BANK_CLAMP_EN clamps each committed weight to [0, W_MAX].
module stdp_weight_bank #(
    parameter int                     buffer_size = 16,
    parameter int                     N_SYN       = 8,
    parameter int                     AW          = 3,
    parameter logic [buffer_size-1:0] W_MAX       = 16'h7FFF,
    parameter logic [buffer_size-1:0] W_INIT      = 16'h0000
) (
    input  logic                         clk,
    input  logic                         reset,
    stdp_bank_if.slave                   bus,
    output logic [N_SYN*buffer_size-1:0] w_prev_o,
    input  logic [N_SYN*buffer_size-1:0] w_new_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPLAY = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [AW:0]            n_changed_q, n_changed_d;
    logic [buffer_size-1:0] main_q [N_SYN];
    logic [buffer_size-1:0] main_d [N_SYN];
    logic [buffer_size-1:0] shadow_q [N_SYN];
    logic [buffer_size-1:0] shadow_d [N_SYN];
    logic [buffer_size-1:0] rd_data_q, rd_data_d;
    logic                   busy_q, done_q, srp_q;
    logic [buffer_size-1:0] commit_val_s;
    logic                   wr_in_range_s, rd_in_range_s;

    // Underflowed values (MSB set) go to zero, overshoots saturate at W_MAX.
    function automatic logic [buffer_size-1:0] clamp_w(input logic [buffer_size-1:0] v);
`ifdef STDP_BANK_CLAMP_EN
        if (v[buffer_size-1]) begin
            clamp_w = {buffer_size{1'b0}};
        end else if (v > W_MAX) begin
            clamp_w = W_MAX;
        end else begin
            clamp_w = v;
        end
`else
        clamp_w = v;
`endif
    endfunction

    assign wr_in_range_s = (32'(bus.wr_addr) < 32'(N_SYN));
    assign rd_in_range_s = (32'(bus.rd_addr) < 32'(N_SYN));
    assign commit_val_s  = clamp_w(shadow_q[idx_q]);

    // Next-state, datapath and host-port logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        n_changed_d = n_changed_q;
        main_d      = main_q;
        shadow_d    = shadow_q;
        rd_data_d   = rd_in_range_s ? main_q[bus.rd_addr] : {buffer_size{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (bus.wr_en && wr_in_range_s) begin
                    main_d[bus.wr_addr] = bus.wr_data;
                end else begin
                    main_d = main_q;
                end
                if (bus.start) begin
                    shadow_d    = main_q;
                    cnt_d       = bus.replay_len;
                    idx_d       = {AW{1'b0}};
                    n_changed_d = {(AW+1){1'b0}};
                    state_d     = (bus.replay_len != 8'd0) ? ST_REPLAY : ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REPLAY: begin
                for (int i = 0; i < N_SYN; i++) begin
                    shadow_d[i] = w_new_i[i*buffer_size +: buffer_size];
                end
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_REPLAY;
                end
            end
            ST_COMMIT: begin
                main_d[idx_q] = commit_val_s;
                if (commit_val_s != main_q[idx_q]) begin
                    n_changed_d = n_changed_q + (AW+1)'(1);
                end else begin
                    n_changed_d = n_changed_q;
                end
                if (idx_q == AW'(N_SYN-1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, weight arrays and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            idx_q       <= {AW{1'b0}};
            n_changed_q <= {(AW+1){1'b0}};
            rd_data_q   <= {buffer_size{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            srp_q       <= 1'b0;
            for (int i = 0; i < N_SYN; i++) begin
                main_q[i]   <= W_INIT;
                shadow_q[i] <= W_INIT;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            n_changed_q <= n_changed_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            srp_q       <= (state_d == ST_REPLAY);
            main_q      <= main_d;
            shadow_q    <= shadow_d;
        end
    end

    for (genvar g = 0; g < N_SYN; g++) begin : g_wprev
        assign w_prev_o[g*buffer_size +: buffer_size] = main_q[g];
    end

    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.start_replay_phase = srp_q;
    assign bus.rd_data            = rd_data_q;
    assign bus.n_changed          = n_changed_q;

endmodule
